// File: rtl/power_series_pkg.sv
// Shared widths, FSM state type and pipeline stage record for the power-series evaluator.
package power_series_pkg;

  localparam int SUM_W  = 32;
  localparam int PROD_W = 40;
  localparam int X_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic              ovf;
    logic [X_W-1:0]    x;
    logic [PROD_W-1:0] pow;
    logic [SUM_W-1:0]  sum;
  } stage_t;

endpackage

// File: rtl/power_series_stage.sv
// One multiply/accumulate stage: pow_k = pow_{k-1} * x, sum_k = sum_{k-1} + pow_k,
// with a sticky overflow flag for product bits above 32 or a sum carry.
module power_series_stage
  import power_series_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  stage_t i_prev,
  output stage_t o_stage
);

  logic [PROD_W-1:0] w_prod;
  logic [SUM_W:0]    w_sum;
  logic              w_ovf;
  stage_t            r_stage;

  // Only the low 32 bits of pow feed the product; any higher bit already implies ovf.
  assign w_prod = PROD_W'(i_prev.pow[SUM_W-1:0]) * PROD_W'(i_prev.x);
  assign w_sum  = {1'b0, i_prev.sum} + {1'b0, w_prod[SUM_W-1:0]};
  assign w_ovf  = i_prev.ovf | (|w_prod[PROD_W-1:SUM_W]) | w_sum[SUM_W]
                | (|i_prev.pow[PROD_W-1:SUM_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage <= '0;
    end else begin
      r_stage.valid <= i_prev.valid;
      r_stage.err   <= i_prev.err;
      r_stage.ovf   <= w_ovf;
      r_stage.x     <= i_prev.x;
      r_stage.pow   <= w_prod;
      r_stage.sum   <= w_sum[SUM_W-1:0];
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/power_series_top.sv
// Streaming evaluator of S(x) = 1 + x + ... + x^(2N) over frames of FRAME samples.
// Define POWER_SERIES_SAT_EN to saturate overflowed sums; otherwise they wrap modulo 2^32.
module power_series_top
  import power_series_pkg::*;
#(
  parameter logic [2:0] N     = 3'b010,
  parameter int         FRAME = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [X_W-1:0]   in_x_input,
  input  logic             start,
  output logic             ready,
  output logic             out_valid_final,
  output logic             error,
  output logic             overflow,
  output logic [SUM_W-1:0] out_sum
);

  localparam int D     = 2 * int'(N);
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  stage_t           r_stage0;
  stage_t           w_pipe [D+1];
  stage_t           w_last;
  logic [D:0]       w_valids;
  logic             w_busy;
  logic [SUM_W-1:0] w_res_sum;
  logic             w_unused;

  logic             r_valid;
  logic             r_err;
  logic             r_ovf;
  logic [SUM_W-1:0] r_sum;

  assign w_pipe[0] = r_stage0;
  assign w_last    = w_pipe[D];
  assign w_busy    = |w_valids;
  assign w_unused  = ^{w_last.x, w_last.pow};

  genvar gi;
  generate
    for (gi = 1; gi <= D; gi = gi + 1) begin : g_stage
      power_series_stage u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_prev  (w_pipe[gi-1]),
        .o_stage (w_pipe[gi])
      );
    end
    for (gi = 0; gi <= D; gi = gi + 1) begin : g_valid
      assign w_valids[gi] = w_pipe[gi].valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(FRAME - 1)) r_state <= FLUSH;
        end
        // The last result is the one leaving with nothing left behind it.
        FLUSH: begin
          if (r_valid && !w_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage0 <= '0;
    end else begin
      r_stage0.valid <= (r_state == RUN);
      r_stage0.err   <= in_x_input[X_W-1];
      r_stage0.ovf   <= 1'b0;
      r_stage0.x     <= in_x_input;
      r_stage0.pow   <= PROD_W'(1);
      r_stage0.sum   <= SUM_W'(1);
    end
  end

  always_comb begin
    w_res_sum = w_last.sum;
    if (w_last.err) begin
      w_res_sum = '0;
    end
`ifdef POWER_SERIES_SAT_EN
    else if (w_last.ovf) begin
      w_res_sum = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_valid <= w_last.valid;
      r_err   <= w_last.valid & w_last.err;
      r_ovf   <= w_last.valid & ~w_last.err & w_last.ovf;
      if (w_last.valid) r_sum <= w_res_sum;
    end
  end

  assign out_valid_final = r_valid;
  assign error           = r_err;
  assign overflow        = r_ovf;
  assign out_sum         = r_sum;

endmodule

// File: tb/tb_power_series_top.sv
// Scoreboard bench: N=2 and N=7 instances share stimulus; a monitor pops expected results.
module tb_power_series_top;

  typedef struct {
    logic [31:0] sum;
    logic        err;
    logic        ovf;
    logic [7:0]  x;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_x_input = 8'h00;
  logic        start = 1'b0;

  logic        ready2, valid2, err2, ovf2;
  logic [31:0] sum2;
  logic        ready7, valid7, err7, ovf7;
  logic [31:0] sum7;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q2[$];
  exp_t q7[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  power_series_top #(.N(3'd2), .FRAME(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_x_input(in_x_input), .start(start),
    .ready(ready2), .out_valid_final(valid2), .error(err2), .overflow(ovf2), .out_sum(sum2)
  );

  power_series_top #(.N(3'd7), .FRAME(4)) u_dut7 (
    .clk(clk), .rst(rst), .in_x_input(in_x_input), .start(start),
    .ready(ready7), .out_valid_final(valid7), .error(err7), .overflow(ovf7), .out_sum(sum7)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Direct polynomial sum at wide precision; overflow means the true sum needs more than 32 bits.
  function automatic exp_t model(input logic [7:0] x, input int n);
    exp_t r;
    logic [127:0] acc, p;
    r.x = x;
    r.due = 0;
    if (x[7]) begin
      r.sum = 32'd0; r.err = 1'b1; r.ovf = 1'b0;
      return r;
    end
    acc = '0;
    p   = 128'd1;
    for (int k = 0; k <= 2 * n; k++) begin
      acc = acc + p;
      p   = p * 128'(x);
    end
    r.err = 1'b0;
    r.ovf = (acc[127:32] != 0);
    r.sum = acc[31:0];
`ifdef POWER_SERIES_SAT_EN
    if (r.ovf) r.sum = 32'hFFFF_FFFF;
`endif
    return r;
  endfunction

  task automatic mon_dut(input int id, input logic v, input logic er, input logic ov,
                         input logic [31:0] s, input logic rdy, input logic prev_rdy);
    exp_t ex;
    int   sz;
    sz = (id == 2) ? q2.size() : q7.size();
    if (v) begin
      if (sz == 0) begin
        chk(1'b0, $sformatf("unexpected_valid_n%0d", id), {30'd0, ov, er, s}, 64'd0);
      end else begin
        ex = (id == 2) ? q2.pop_front() : q7.pop_front();
        $display("n%0d x=%02h sum=%08h err=%0d ovf=%0d cycle=%0d", id, ex.x, s, er, ov, cyc);
        chk({ov, er, s} == {ex.ovf, ex.err, ex.sum}, $sformatf("result_n%0d_x%02h", id, ex.x),
            {30'd0, ov, er, s}, {30'd0, ex.ovf, ex.err, ex.sum});
        chk(cyc == ex.due, $sformatf("latency_n%0d", id), 64'(cyc), 64'(ex.due));
      end
    end else begin
      chk(!er && !ov, $sformatf("flags_without_valid_n%0d", id), {62'd0, ov, er}, 64'd0);
    end
    sz = (id == 2) ? q2.size() : q7.size();
    if (rdy && !prev_rdy)
      chk(sz == 0, $sformatf("ready_before_last_n%0d", id), 64'(sz), 64'd0);
  endtask

  task automatic monitor();
    logic p2 = 1'b1;
    logic p7 = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q2.delete();
        q7.delete();
        chk({ready2, valid2, err2, ovf2, sum2} == {4'b1000, 32'd0}, "reset_state_n2",
            {28'd0, ready2, valid2, err2, ovf2, sum2}, {28'd0, 4'b1000, 32'd0});
        chk({ready7, valid7, err7, ovf7, sum7} == {4'b1000, 32'd0}, "reset_state_n7",
            {28'd0, ready7, valid7, err7, ovf7, sum7}, {28'd0, 4'b1000, 32'd0});
      end else begin
        mon_dut(2, valid2, err2, ovf2, sum2, ready2, p2);
        mon_dut(7, valid7, err7, ovf7, sum7, ready7, p7);
      end
      p2 = ready2;
      p7 = ready7;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready2 && ready7) return;
      @(posedge clk); #1;
    end
    chk(1'b0, "ready_timeout", {62'd0, ready7, ready2}, 64'd3);
  endtask

  task automatic drive_sample(input logic [7:0] x, input bit noise);
    exp_t e;
    in_x_input = x;
    e = model(x, 2); e.due = cyc + 1 + 4 + 1;  q2.push_back(e);
    e = model(x, 7); e.due = cyc + 1 + 14 + 1; q7.push_back(e);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input bit noise);
    wait_ready();
    start = 1'b1;
    in_x_input = 8'($urandom);
    @(posedge clk); #1;
    drive_sample(a, noise);
    drive_sample(b, noise);
    drive_sample(c, noise);
    drive_sample(d, noise);
    in_x_input = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      start = (noise && !ready2 && !ready7) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  function automatic logic [7:0] rand_x();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(128, 255));
      1:       return 8'($urandom_range(0, 7));
      default: return 8'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic stimulus();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_frame(8'h06, 8'h0F, 8'h01, 8'h00, 1'b0);
    do_frame(8'h7F, 8'hE0, 8'h80, 8'hFF, 1'b1);
    do_frame(8'h00, 8'h01, 8'h02, 8'h04, 1'b1);
    for (int f = 0; f < 20; f++)
      do_frame(rand_x(), rand_x(), rand_x(), rand_x(), 1'b1);

    // Reset in the middle of a frame: in-flight samples must vanish.
    wait_ready();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_sample(8'h06, 1'b0);
    drive_sample(8'h03, 1'b0);
    in_x_input = 8'h05;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    do_frame(8'h06, 8'h0F, 8'h7F, 8'hE0, 1'b0);
    wait_ready();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        repeat (20000) @(posedge clk);
        chk(1'b0, "global_timeout", 64'(cyc), 64'd20000);
      end
    join_any
    disable fork;
    chk(q2.size() == 0, "leftover_n2", 64'(q2.size()), 64'd0);
    chk(q7.size() == 0, "leftover_n7", 64'(q7.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
